// File: rtl/refractory_threshold_unit_pkg.sv
// Shared fixed-point defaults and helpers for the CyNAPSE threshold/reset stage.
// Helpers work on a wide container; callers size the result back down with a cast.
package refractory_threshold_unit_pkg;

    localparam int INTEGER_WIDTH_DEF   = 16;
    localparam int DATA_WIDTH_FRAC_DEF = 32;
    localparam int DATA_WIDTH_DEF      = INTEGER_WIDTH_DEF + DATA_WIDTH_FRAC_DEF;
    localparam int NEURON_COUNT_DEF    = 32;
    localparam int NEURON_ID_WIDTH_DEF = 5;
    localparam int TS_WIDTH_DEF        = 16;

    localparam int FX_MAX_W = 64;
    typedef logic [FX_MAX_W-1:0] fx_wide_t;

    typedef enum logic [1:0] {
        EVAL_PASS   = 2'd0,
        EVAL_FIRE   = 2'd1,
        EVAL_REFRAC = 2'd2
    } eval_kind_e;

    // Integer-only reset value placed above an all-zero fractional field.
    function automatic fx_wide_t vreset_extend(input fx_wide_t int_part, input int unsigned frac_bits);
        return int_part << frac_bits;
    endfunction

    function automatic fx_wide_t sat_add_u(input fx_wide_t a, input fx_wide_t b, input fx_wide_t limit);
        logic [FX_MAX_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, limit}) ? limit : sum[FX_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/refractory_threshold_unit_if.sv
// Evaluation request / result bundle between the membrane datapath, this stage and the spike queue.
interface refractory_threshold_unit_if #(
    parameter int INTEGER_WIDTH   = refractory_threshold_unit_pkg::INTEGER_WIDTH_DEF,
    parameter int DATA_WIDTH_FRAC = refractory_threshold_unit_pkg::DATA_WIDTH_FRAC_DEF,
    parameter int NEURON_ID_WIDTH = refractory_threshold_unit_pkg::NEURON_ID_WIDTH_DEF,
    parameter int TS_WIDTH        = refractory_threshold_unit_pkg::TS_WIDTH_DEF
) ();
    localparam int DATA_WIDTH = INTEGER_WIDTH + DATA_WIDTH_FRAC;

    logic                       in_valid;
    logic [NEURON_ID_WIDTH-1:0] in_neuron_id;
    logic [DATA_WIDTH-1:0]      vmem;
    logic [DATA_WIDTH-1:0]      vth;
    logic [INTEGER_WIDTH-1:0]   vreset;
    logic [TS_WIDTH-1:0]        refrac_period;
    logic [DATA_WIDTH-1:0]      theta_inc;
    logic                       timestep_advance;

    logic                       out_valid;
    logic [NEURON_ID_WIDTH-1:0] out_neuron_id;
    logic [DATA_WIDTH-1:0]      vmem_out;
    logic                       spike_out;
    logic                       refrac_out;
    logic [TS_WIDTH-1:0]        current_timestep;

    modport master (
        output in_valid, in_neuron_id, vmem, vth, vreset, refrac_period, theta_inc, timestep_advance,
        input  out_valid, out_neuron_id, vmem_out, spike_out, refrac_out, current_timestep
    );

    modport slave (
        input  in_valid, in_neuron_id, vmem, vth, vreset, refrac_period, theta_inc, timestep_advance,
        output out_valid, out_neuron_id, vmem_out, spike_out, refrac_out, current_timestep
    );
endinterface

// File: rtl/refractory_threshold_unit_neuron_state_bank.sv
// Per-neuron spike history and adaptive threshold storage.
// Combinational read so a same-cycle evaluation sees the value written at the previous edge.
module neuron_state_bank #(
    parameter int NEURON_COUNT    = 32,
    parameter int NEURON_ID_WIDTH = 5,
    parameter int TS_WIDTH        = 16,
    parameter int DATA_WIDTH      = 48,
    parameter bit ADAPT_EN        = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NEURON_ID_WIDTH-1:0] rd_id_i,
    output logic                       rd_has_spiked_o,
    output logic [TS_WIDTH-1:0]        rd_last_spike_o,
    output logic [DATA_WIDTH-1:0]      rd_theta_o,
    input  logic                       wr_en_i,
    input  logic [NEURON_ID_WIDTH-1:0] wr_id_i,
    input  logic [TS_WIDTH-1:0]        wr_last_spike_i,
    input  logic [DATA_WIDTH-1:0]      wr_theta_i
);
    logic                  has_spiked_arr [NEURON_COUNT];
    logic [TS_WIDTH-1:0]   last_spike_arr [NEURON_COUNT];
    logic [DATA_WIDTH-1:0] theta_arr      [NEURON_COUNT];

    genvar gi;
    generate
        for (gi = 0; gi < NEURON_COUNT; gi++) begin : g_entry
            logic                wr_hit;
            logic                has_spiked_q;
            logic [TS_WIDTH-1:0] last_spike_q;

            assign wr_hit = wr_en_i && (wr_id_i == NEURON_ID_WIDTH'(gi));

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    has_spiked_q <= 1'b0;
                    last_spike_q <= '0;
                end else if (wr_hit) begin
                    has_spiked_q <= 1'b1;
                    last_spike_q <= wr_last_spike_i;
                end
            end

            assign has_spiked_arr[gi] = has_spiked_q;
            assign last_spike_arr[gi] = last_spike_q;

            if (ADAPT_EN) begin : g_theta
                logic [DATA_WIDTH-1:0] theta_q;
                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        theta_q <= '0;
                    end else if (wr_hit) begin
                        theta_q <= wr_theta_i;
                    end
                end
                assign theta_arr[gi] = theta_q;
            end else begin : g_no_theta
                assign theta_arr[gi] = '0;
            end
        end
    endgenerate

    // An index with no stored entry matches nothing and reads as a fresh neuron.
    always_comb begin
        rd_has_spiked_o = 1'b0;
        rd_last_spike_o = '0;
        rd_theta_o      = '0;
        for (int i = 0; i < NEURON_COUNT; i++) begin
            if (rd_id_i == NEURON_ID_WIDTH'(i)) begin
                rd_has_spiked_o = has_spiked_arr[i];
                rd_last_spike_o = last_spike_arr[i];
                rd_theta_o      = theta_arr[i];
            end
        end
    end

endmodule

// File: rtl/refractory_threshold_unit.sv
// Threshold / reset stage: one neuron evaluation per clock, refractory gating,
// optional adaptive threshold, registered results one cycle later.
module refractory_threshold_unit
    import refractory_threshold_unit_pkg::*;
#(
    parameter int INTEGER_WIDTH   = INTEGER_WIDTH_DEF,
    parameter int DATA_WIDTH_FRAC = DATA_WIDTH_FRAC_DEF,
    parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int NEURON_COUNT    = NEURON_COUNT_DEF,
    parameter int NEURON_ID_WIDTH = NEURON_ID_WIDTH_DEF,
    parameter int TS_WIDTH        = TS_WIDTH_DEF,
    parameter bit ADAPT_EN        = 1'b1,
    parameter logic [DATA_WIDTH-1:0] THETA_MAX = DATA_WIDTH'(48'h0010_0000_0000)
) (
    input logic                        clk_i,
    input logic                        rst_i,
    refractory_threshold_unit_if.slave bus_io
);
    logic [TS_WIDTH-1:0]        ts_q, ts_d;
    logic                       out_valid_q, out_valid_d;
    logic [NEURON_ID_WIDTH-1:0] out_id_q, out_id_d;
    logic [DATA_WIDTH-1:0]      vmem_out_q, vmem_out_d;
    logic                       spike_q, spike_d;
    logic                       refrac_q, refrac_d;

    logic                       rd_has_spiked;
    logic [TS_WIDTH-1:0]        rd_last_spike;
    logic [DATA_WIDTH-1:0]      rd_theta;
    logic [TS_WIDTH-1:0]        elapsed;
    logic [DATA_WIDTH-1:0]      vreset_ext;
    logic [DATA_WIDTH-1:0]      theta_new;
    logic signed [DATA_WIDTH:0] vmem_ext;
    logic signed [DATA_WIDTH:0] vth_eff;
    eval_kind_e                 kind;
    logic                       wr_en;

    neuron_state_bank #(
        .NEURON_COUNT   (NEURON_COUNT),
        .NEURON_ID_WIDTH(NEURON_ID_WIDTH),
        .TS_WIDTH       (TS_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .ADAPT_EN       (ADAPT_EN)
    ) u_state_bank (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rd_id_i        (bus_io.in_neuron_id),
        .rd_has_spiked_o(rd_has_spiked),
        .rd_last_spike_o(rd_last_spike),
        .rd_theta_o     (rd_theta),
        .wr_en_i        (wr_en),
        .wr_id_i        (bus_io.in_neuron_id),
        .wr_last_spike_i(ts_q),
        .wr_theta_i     (theta_new)
    );

    always_comb begin
        ts_d       = ts_q + TS_WIDTH'(bus_io.timestep_advance);
        vreset_ext = DATA_WIDTH'(vreset_extend(fx_wide_t'(bus_io.vreset), DATA_WIDTH_FRAC));
        // Modular difference keeps the window correct across counter wrap.
        elapsed    = ts_q - rd_last_spike;
        // One extra bit so base threshold plus theta can never overflow.
        vth_eff    = $signed({bus_io.vth[DATA_WIDTH-1], bus_io.vth}) + $signed({1'b0, rd_theta});
        vmem_ext   = $signed({bus_io.vmem[DATA_WIDTH-1], bus_io.vmem});
        theta_new  = DATA_WIDTH'(sat_add_u(fx_wide_t'(rd_theta), fx_wide_t'(bus_io.theta_inc),
                                           fx_wide_t'(THETA_MAX)));

        if (rd_has_spiked && (elapsed < bus_io.refrac_period)) begin
            kind = EVAL_REFRAC;
        end else if (vmem_ext >= vth_eff) begin
            kind = EVAL_FIRE;
        end else begin
            kind = EVAL_PASS;
        end

        wr_en       = bus_io.in_valid && (kind == EVAL_FIRE);
        out_valid_d = bus_io.in_valid;
        out_id_d    = out_id_q;
        vmem_out_d  = vmem_out_q;
        spike_d     = spike_q;
        refrac_d    = refrac_q;

        if (bus_io.in_valid) begin
            out_id_d = bus_io.in_neuron_id;
            unique case (kind)
                EVAL_REFRAC: begin
                    vmem_out_d = vreset_ext;
                    spike_d    = 1'b0;
                    refrac_d   = 1'b1;
                end
                EVAL_FIRE: begin
                    vmem_out_d = vreset_ext;
                    spike_d    = 1'b1;
                    refrac_d   = 1'b0;
                end
                default: begin
                    vmem_out_d = bus_io.vmem;
                    spike_d    = 1'b0;
                    refrac_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts_q        <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            vmem_out_q  <= '0;
            spike_q     <= 1'b0;
            refrac_q    <= 1'b0;
        end else begin
            ts_q        <= ts_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            vmem_out_q  <= vmem_out_d;
            spike_q     <= spike_d;
            refrac_q    <= refrac_d;
        end
    end

    assign bus_io.out_valid        = out_valid_q;
    assign bus_io.out_neuron_id    = out_id_q;
    assign bus_io.vmem_out         = vmem_out_q;
    assign bus_io.spike_out        = spike_q;
    assign bus_io.refrac_out       = refrac_q;
    assign bus_io.current_timestep = ts_q;

endmodule

// File: tb/tb_refractory_threshold_unit.sv
// Bench for refractory_threshold_unit: directed scenarios plus randomized traffic
// checked against an arithmetic per-neuron model.
module tb_refractory_threshold_unit;
    localparam int     NC          = 24;
    localparam longint ONE         = 64'sh1_0000_0000;
    localparam longint THETA_MAX_V = 64'sh0010_0000_0000;
    localparam logic [47:0] FX_M1  = 48'hFFFF_0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    refractory_threshold_unit_if #(.NEURON_ID_WIDTH(5), .TS_WIDTH(16)) bus ();
    refractory_threshold_unit_if #(.NEURON_ID_WIDTH(5), .TS_WIDTH(4))  bw ();

    refractory_threshold_unit #(.NEURON_COUNT(NC), .TS_WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .bus_io(bus));
    refractory_threshold_unit #(.NEURON_COUNT(32), .TS_WIDTH(4)) dut_w (
        .clk_i(clk), .rst_i(rst), .bus_io(bw));

    int tests_run    = 0;
    int tests_failed = 0;

    bit          m_has   [NC];
    int unsigned m_last  [NC];
    longint      m_theta [NC];
    int unsigned m_ts;
    bit          e_valid, e_spike, e_refrac;
    int          e_id;
    longint      e_vmem;

    function automatic logic [71:0] obs_main();
        return {bus.out_valid, bus.out_neuron_id, bus.spike_out, bus.refrac_out,
                bus.vmem_out, bus.current_timestep};
    endfunction

    function automatic logic [71:0] exp_main();
        return {e_valid, 5'(e_id), e_spike, e_refrac, e_vmem[47:0], 16'(m_ts)};
    endfunction

    function automatic logic [59:0] obs_w();
        return {bw.out_valid, bw.out_neuron_id, bw.spike_out, bw.refrac_out,
                bw.vmem_out, bw.current_timestep};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_has[i] = 1'b0; m_last[i] = 0; m_theta[i] = 0;
        end
        m_ts = 0; e_valid = 0; e_spike = 0; e_refrac = 0; e_id = 0; e_vmem = 0;
    endtask

    // Drive one cycle on the main DUT, advance the model, land on the next negedge.
    task automatic apply(input bit valid, input int id, input longint vmem, input longint vth,
                         input int vreset, input int period, input longint inc, input bit adv);
        bit legal, has, refr, fire;
        longint th, sum;
        bus.in_valid = valid; bus.in_neuron_id = 5'(id);
        bus.vmem = vmem[47:0]; bus.vth = vth[47:0]; bus.vreset = 16'(vreset);
        bus.refrac_period = 16'(period); bus.theta_inc = inc[47:0]; bus.timestep_advance = adv;
        legal = (id < NC);
        has   = legal ? m_has[id] : 1'b0;
        th    = legal ? m_theta[id] : 0;
        refr  = has && (((m_ts - m_last[id]) % 65536) < period);
        fire  = !refr && (vmem >= vth + th);
        if (valid) begin
            e_valid = 1; e_id = id; e_spike = fire; e_refrac = refr;
            e_vmem = (refr || fire) ? (longint'(vreset) <<< 32) : vmem;
            if (fire && legal) begin
                m_has[id] = 1; m_last[id] = m_ts;
                sum = th + inc;
                m_theta[id] = (sum > THETA_MAX_V) ? THETA_MAX_V : sum;
            end
        end else begin
            e_valid = 0;
        end
        if (adv) m_ts = (m_ts + 1) % 65536;
        @(negedge clk);
        if (valid)
            $display("[TB] txn id=%0d spike=%0b refrac=%0b vmem_out=%h ts=%0d",
                     bus.out_neuron_id, bus.spike_out, bus.refrac_out, bus.vmem_out, bus.current_timestep);
    endtask

    task automatic apply_w(input bit valid, input int id, input longint vmem, input longint vth,
                           input int period, input bit adv);
        bw.in_valid = valid; bw.in_neuron_id = 5'(id);
        bw.vmem = vmem[47:0]; bw.vth = vth[47:0]; bw.vreset = 16'hFFFF;
        bw.refrac_period = 4'(period); bw.theta_inc = '0; bw.timestep_advance = adv;
        @(negedge clk);
        if (valid)
            $display("[TB] txn(w) id=%0d spike=%0b refrac=%0b ts=%0d",
                     bw.out_neuron_id, bw.spike_out, bw.refrac_out, bw.current_timestep);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1; bus.in_neuron_id = 5'd3; bus.vmem = 48'h7; bus.vth = '0;
        bus.vreset = 16'h5; bus.refrac_period = '0; bus.theta_inc = '0; bus.timestep_advance = 1;
        bw.in_valid = 1; bw.in_neuron_id = 5'd1; bw.vmem = 48'h9; bw.vth = '0;
        bw.vreset = '0; bw.refrac_period = '0; bw.theta_inc = '0; bw.timestep_advance = 1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (obs_main() !== 72'd0) begin
            tests_failed++; $display("FAIL reset_main: got %h expected 0", obs_main());
        end
        tests_run++;
        if (obs_w() !== 60'd0) begin
            tests_failed++; $display("FAIL reset_wrap_dut: got %h expected 0", obs_w());
        end
        rst = 1'b0;
        bus.in_valid = 0; bus.timestep_advance = 0;
        bw.in_valid = 0; bw.timestep_advance = 0;
        model_reset();
    endtask

    task automatic test_wrap();
        logic [59:0] exp_v;
        apply_w(1, 7, 5 * ONE, 4 * ONE, 3, 0);
        exp_v = {1'b1, 5'd7, 1'b1, 1'b0, FX_M1, 4'd0};
        tests_run++;
        if (obs_w() !== exp_v) begin
            tests_failed++; $display("FAIL wrap_first_spike: got %h expected %h", obs_w(), exp_v);
        end
        for (int k = 0; k < 14; k++) apply_w(0, 0, 0, 0, 3, 1);
        apply_w(1, 2, 5 * ONE, 4 * ONE, 3, 1);
        exp_v = {1'b1, 5'd2, 1'b1, 1'b0, FX_M1, 4'd15};
        tests_run++;
        if (obs_w() !== exp_v) begin
            tests_failed++; $display("FAIL wrap_spike_t14: got %h expected %h", obs_w(), exp_v);
        end
        apply_w(1, 2, 5 * ONE, 4 * ONE, 3, 1);
        exp_v = {1'b1, 5'd2, 1'b0, 1'b1, FX_M1, 4'd0};
        tests_run++;
        if (obs_w() !== exp_v) begin
            tests_failed++; $display("FAIL wrap_refrac_t15: got %h expected %h", obs_w(), exp_v);
        end
        apply_w(1, 2, 5 * ONE, 4 * ONE, 3, 1);
        exp_v = {1'b1, 5'd2, 1'b0, 1'b1, FX_M1, 4'd1};
        tests_run++;
        if (obs_w() !== exp_v) begin
            tests_failed++; $display("FAIL wrap_refrac_t0: got %h expected %h", obs_w(), exp_v);
        end
        apply_w(1, 2, 5 * ONE, 4 * ONE, 3, 0);
        exp_v = {1'b1, 5'd2, 1'b1, 1'b0, FX_M1, 4'd1};
        tests_run++;
        if (obs_w() !== exp_v) begin
            tests_failed++; $display("FAIL wrap_fire_t1: got %h expected %h", obs_w(), exp_v);
        end
        bw.in_valid = 0;
    endtask

    task automatic test_fire_basic();
        logic [71:0] exp_v;
        apply(1, 3, 5 * ONE, 4 * ONE, -1, 0, 0, 0);
        exp_v = {1'b1, 5'd3, 1'b1, 1'b0, FX_M1, 16'd0};
        tests_run++;
        if (obs_main() !== exp_v) begin
            tests_failed++; $display("FAIL basic_fire: got %h expected %h", obs_main(), exp_v);
        end
        apply(1, 3, 3 * ONE + ONE / 2, 4 * ONE, -1, 0, 0, 0);
        exp_v = {1'b1, 5'd3, 1'b0, 1'b0, 48'h0003_8000_0000, 16'd0};
        tests_run++;
        if (obs_main() !== exp_v) begin
            tests_failed++; $display("FAIL below_threshold: got %h expected %h", obs_main(), exp_v);
        end
        apply(0, 9, 0, 0, 0, 0, 0, 0);
        exp_v = {1'b0, 5'd3, 1'b0, 1'b0, 48'h0003_8000_0000, 16'd0};
        tests_run++;
        if (obs_main() !== exp_v) begin
            tests_failed++; $display("FAIL idle_hold: got %h expected %h", obs_main(), exp_v);
        end
    endtask

    task automatic test_refractory();
        logic [71:0] exp_v;
        for (int k = 0; k < 10; k++) apply(0, 0, 0, 0, 0, 0, 0, 1);
        apply(1, 5, 9 * ONE, 4 * ONE, -1, 2, 0, 0);
        exp_v = {1'b1, 5'd5, 1'b1, 1'b0, FX_M1, 16'd10};
        tests_run++;
        if (obs_main() !== exp_v) begin
            tests_failed++; $display("FAIL refrac_first_spike: got %h expected %h", obs_main(), exp_v);
        end
        apply(1, 5, 9 * ONE, 4 * ONE, -1, 2, 0, 1);
        exp_v = {1'b1, 5'd5, 1'b0, 1'b1, FX_M1, 16'd11};
        tests_run++;
        if (obs_main() !== exp_v) begin
            tests_failed++; $display("FAIL refrac_t10: got %h expected %h", obs_main(), exp_v);
        end
        apply(1, 5, 9 * ONE, 4 * ONE, -1, 2, 0, 1);
        exp_v = {1'b1, 5'd5, 1'b0, 1'b1, FX_M1, 16'd12};
        tests_run++;
        if (obs_main() !== exp_v) begin
            tests_failed++; $display("FAIL refrac_t11: got %h expected %h", obs_main(), exp_v);
        end
        apply(1, 5, 9 * ONE, 4 * ONE, -1, 2, 0, 0);
        exp_v = {1'b1, 5'd5, 1'b1, 1'b0, FX_M1, 16'd12};
        tests_run++;
        if (obs_main() !== exp_v) begin
            tests_failed++; $display("FAIL refrac_end_t12: got %h expected %h", obs_main(), exp_v);
        end
    endtask

    task automatic test_adapt();
        logic [71:0] exp_v;
        longint v24, v17m;
        v24  = longint'(2.4 * 4294967296.0);
        v17m = 17 * ONE - 1;
        for (int k = 0; k < 3; k++) begin
            apply(1, 0, 10 * ONE, ONE, -1, 0, ONE / 2, 0);
            tests_run++;
            if (bus.spike_out !== 1'b1) begin
                tests_failed++; $display("FAIL adapt_spike%0d: got %0b expected 1", k, bus.spike_out);
            end
        end
        apply(1, 0, v24, ONE, -1, 0, 0, 0);
        exp_v = {1'b1, 5'd0, 1'b0, 1'b0, v24[47:0], 16'd12};
        tests_run++;
        if (obs_main() !== exp_v) begin
            tests_failed++; $display("FAIL adapt_2p4_quiet: got %h expected %h", obs_main(), exp_v);
        end
        apply(1, 0, 2 * ONE + ONE / 2, ONE, -1, 0, 0, 0);
        exp_v = {1'b1, 5'd0, 1'b1, 1'b0, FX_M1, 16'd12};
        tests_run++;
        if (obs_main() !== exp_v) begin
            tests_failed++; $display("FAIL adapt_2p5_fire: got %h expected %h", obs_main(), exp_v);
        end
        for (int k = 0; k < 4; k++) apply(1, 1, 100 * ONE, ONE, -1, 0, 7 * ONE, 0);
        apply(1, 1, 17 * ONE, ONE, -1, 0, 0, 0);
        exp_v = {1'b1, 5'd1, 1'b1, 1'b0, FX_M1, 16'd12};
        tests_run++;
        if (obs_main() !== exp_v) begin
            tests_failed++; $display("FAIL theta_sat_fire: got %h expected %h", obs_main(), exp_v);
        end
        apply(1, 1, v17m, ONE, -1, 0, 0, 0);
        exp_v = {1'b1, 5'd1, 1'b0, 1'b0, v17m[47:0], 16'd12};
        tests_run++;
        if (obs_main() !== exp_v) begin
            tests_failed++; $display("FAIL theta_sat_quiet: got %h expected %h", obs_main(), exp_v);
        end
    endtask

    task automatic test_reset_mid();
        logic [71:0] exp_v;
        apply(1, 4, 9 * ONE, 4 * ONE, -1, 5, ONE / 2, 0);
        apply(1, 4, 9 * ONE, 4 * ONE, -1, 5, 0, 0);
        tests_run++;
        if (bus.refrac_out !== 1'b1) begin
            tests_failed++; $display("FAIL pre_reset_refrac: got %0b expected 1", bus.refrac_out);
        end
        rst = 1'b1;
        bus.in_valid = 1; bus.timestep_advance = 1;
        @(negedge clk);
        tests_run++;
        if (obs_main() !== 72'd0) begin
            tests_failed++; $display("FAIL reset_mid_discard: got %h expected 0", obs_main());
        end
        rst = 1'b0;
        model_reset();
        apply(1, 4, ONE, ONE, -1, 5, 0, 0);
        exp_v = {1'b1, 5'd4, 1'b1, 1'b0, FX_M1, 16'd0};
        tests_run++;
        if (obs_main() !== exp_v) begin
            tests_failed++; $display("FAIL reset_mid_state_cleared: got %h expected %h", obs_main(), exp_v);
        end
    endtask

    task automatic test_random_back_to_back();
        int id, vreset, period, r;
        longint vmem, vth, inc;
        bit valid, adv;
        for (int k = 0; k < 300; k++) begin
            id = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 31));
            r = int'($urandom_range(0, 19));
            if (r == 0)      vmem = -(longint'(1) <<< 47);
            else if (r == 1) vmem = (longint'(1) <<< 47) - 1;
            else             vmem = (longint'(int'($urandom_range(0, 40)) - 20) <<< 32) + longint'($urandom);
            r = int'($urandom_range(0, 19));
            if (r == 0)      vth = -(longint'(1) <<< 47);
            else if (r == 1) vth = (longint'(1) <<< 47) - 1;
            else             vth = (longint'(int'($urandom_range(0, 20)) - 5) <<< 32) + longint'($urandom);
            vreset = int'($urandom_range(0, 6)) - 3;
            period = int'($urandom_range(0, 4));
            inc    = longint'($urandom_range(0, 12)) <<< 30;
            valid  = ($urandom_range(0, 7) != 0);
            adv    = ($urandom_range(0, 2) == 0);
            apply(valid, id, vmem, vth, vreset, period, inc, adv);
            tests_run++;
            if (obs_main() !== exp_main()) begin
                tests_failed++;
                $display("FAIL random_txn%0d: got %h expected %h", k, obs_main(), exp_main());
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_wrap();
        test_fire_basic();
        test_refractory();
        test_adapt();
        test_reset_mid();
        test_random_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/refractory_threshold_unit.md
Name: refractory_threshold_unit

Overview:
- Next-generation threshold/reset stage for the CyNAPSE neuron pipeline. Time-multiplexed over NEURON_COUNT neurons.
- Per neuron, on each evaluation: compares Vmem against an effective threshold and emits a spike. On a spike it resets Vmem to Vreset.
- Enforces a per-neuron refractory period counted in timesteps.
- Optionally adapts each neuron's threshold (theta) upward on every spike.
- Sits between the membrane-update datapath and the spike/output queue. Registered output, one evaluation per clock.

Parameters:
- INTEGER_WIDTH, 16, integer bits of fixed-point values.
- DATA_WIDTH_FRAC, 32, fractional bits.
- DATA_WIDTH, INTEGER_WIDTH+DATA_WIDTH_FRAC, full fixed-point width.
- NEURON_COUNT, 32, number of neurons with stored state.
- NEURON_ID_WIDTH, 5, neuron index width; must satisfy 2^NEURON_ID_WIDTH >= NEURON_COUNT.
- TS_WIDTH, 16, width of the timestep counter, stamps and refractory period.
- ADAPT_EN, 1, 1 = adaptive threshold enabled; 0 = theta held at zero and its storage removed.
- THETA_MAX, 48'h0010_0000_0000, saturation limit of theta (positive, DATA_WIDTH bits).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- InValid  in  1  evaluate one neuron this cycle.
- InNeuronID  in  NEURON_ID_WIDTH  neuron index.
- Vmem  in  DATA_WIDTH  signed membrane potential.
- Vth  in  DATA_WIDTH  signed base threshold.
- Vreset  in  INTEGER_WIDTH  signed reset value, integer part only.
- RefracPeriod  in  TS_WIDTH  refractory length in timesteps; 0 = none.
- ThetaInc  in  DATA_WIDTH  unsigned theta increment per spike.
- TimestepAdvance  in  1  single-cycle pulse that ends the current timestep.
- OutValid  out  1  output registers hold a result.
- OutNeuronID  out  NEURON_ID_WIDTH  echoed index.
- VmemOut  out  DATA_WIDTH  signed updated membrane potential.
- SpikeOut  out  1  neuron fired.
- RefracOut  out  1  neuron was refractory; its input was suppressed.
- CurrentTimestep  out  TS_WIDTH  free-running timestep counter.

Behaviour:
- Reset (Clock edge with Reset=1):
  - Outputs: OutValid=0, SpikeOut=0, RefracOut=0, VmemOut=0, OutNeuronID=0, CurrentTimestep=0.
  - All neuron state: theta[n]=0, hasSpiked[n]=0, lastSpike[n]=0.
  - Reset mid-stream discards any in-flight evaluation; no output is produced for that cycle.
- Timestep counter: CurrentTimestep increments by 1 on TimestepAdvance and wraps modulo 2^TS_WIDTH.
- Latency: exactly 1 cycle. OutValid(t+1) = InValid(t). No backpressure: the consumer must accept every OutValid.
- Evaluation of neuron n with timestep T = pre-increment CurrentTimestep (also when TimestepAdvance coincides):
  - Vreset_Ext = {Vreset, DATA_WIDTH_FRAC zeros}.
  - refractory = hasSpiked[n] AND ((T - lastSpike[n]) mod 2^TS_WIDTH) < RefracPeriod.
  - VthEff = Vth + theta[n], computed at DATA_WIDTH+1 bits signed, so no overflow occurs.
  - Compare: Vmem sign-extended to DATA_WIDTH+1 >= VthEff.
- Output priority:
  - If refractory: SpikeOut=0, RefracOut=1, VmemOut=Vreset_Ext (clamped); state unchanged.
  - Else if Vmem >= VthEff: SpikeOut=1, RefracOut=0, VmemOut=Vreset_Ext. State update: lastSpike[n]=T, hasSpiked[n]=1, theta[n]=min(theta[n]+ThetaInc, THETA_MAX) if ADAPT_EN.
  - Else: SpikeOut=0, RefracOut=0, VmemOut=Vmem.
- State write timing: state updates at the same edge as the output registers. Back-to-back evaluations of the same neuron see updated state with no hazard; state reads are combinational from the register array.
- Illegal index: InNeuronID >= NEURON_COUNT evaluates as non-refractory with theta=0 and writes no state.
- Wrap-around: correct for RefracPeriod < 2^TS_WIDTH. hasSpiked prevents false refractoriness before a neuron's first spike.
- OutValid=0 cycles: outputs hold their previous values except OutValid itself.

Decomposition:
- Shared package/header cynapse_fixed_defs: INTEGER_WIDTH, DATA_WIDTH_FRAC and DATA_WIDTH defaults; a Vreset-extension macro/function; a saturating unsigned add function.
- Sub-module neuron_state_bank: per-neuron lastSpike, hasSpiked and theta storage; combinational read port; one synchronous write port; synchronous clear on Reset.
- Top level: timestep counter, compare/mux logic, output registers.

Test Plan:
- Basic fire: Reset, then n=3 with Vmem=5.0, Vth=4.0, Vreset=-1, RefracPeriod=0 -> next cycle OutValid=1, SpikeOut=1, VmemOut=-1.0, OutNeuronID=3.
- Below threshold: n=3, Vmem=3.5, Vth=4.0 -> SpikeOut=0, RefracOut=0, VmemOut=3.5.
- Refractory window:
  - Setup: RefracPeriod=2; n=5 spikes at T=10.
  - Evaluate Vmem=9.0 at T=10 and T=11 -> RefracOut=1, SpikeOut=0, VmemOut=Vreset.
  - Evaluate at T=12 -> SpikeOut=1.
- Timestep wrap: TS_WIDTH=4, RefracPeriod=3, spike at T=14 -> refractory at T=15 and T=0; fires at T=1.
- Adaptation:
  - Setup: ADAPT_EN=1, ThetaInc=0.5, Vth=1.0; three spikes on n=0.
  - Expected: theta=1.5; Vmem=2.4 no spike; Vmem=2.5 spikes.
  - Saturation: theta reaches THETA_MAX and does not exceed it.
- Reset mid-operation: assert Reset in the same cycle as InValid -> OutValid=0 next cycle. Subsequent evaluation of a previously refractory neuron -> RefracOut=0, theta=0, CurrentTimestep=0.
